// File: rtl/snapshot_writer_pkg.sv
// snapshot_writer_pkg: FSM encodings, filter codes and pixel packing shared by the snapshot writer
package snapshot_writer_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;
  localparam logic [2:0] F_NONE   = 3'd0;
  localparam logic [2:0] F_INVERT = 3'd1;
  localparam logic [2:0] F_GRAY   = 3'd2;
  localparam logic [2:0] F_SEPIA  = 3'd3;
  localparam logic [2:0] F_EDGE   = 3'd4;
  function automatic logic [11:0] pack12(input logic [23:0] p);
    return {p[23:20], p[15:12], p[7:4]};
  endfunction
endpackage

// File: rtl/snapshot_writer_window_addr_gen.sv
// window_addr_gen: capture-window membership test and saturating frame-buffer address counter
module window_addr_gen #(
  parameter int WIN_X0 = 0,
  parameter int WIN_Y0 = 0,
  parameter int WIN_W  = 320,
  parameter int WIN_H  = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        in_win,
  output logic [16:0] addr,
  output logic        last
);
  localparam logic [11:0] XB = 12'(WIN_X0);
  localparam logic [11:0] XE = 12'(WIN_X0 + WIN_W);
  localparam logic [10:0] YB = 11'(WIN_Y0);
  localparam logic [10:0] YE = 11'(WIN_Y0 + WIN_H);
  localparam logic [16:0] LAST_ADDR = 17'(WIN_W * WIN_H - 1);
  assign in_win = {1'b0, hcount} >= XB && {1'b0, hcount} < XE &&
                  {1'b0, vcount} >= YB && {1'b0, vcount} < YE;
  assign last = addr == LAST_ADDR;
  // Counter stops at the final address so it can never wrap back onto pixel 0
  always_ff @(posedge clk)
    if (rst || clr) addr <= '0;
    else if (en && in_win && !last) addr <= addr + 17'd1;
endmodule

// File: rtl/snapshot_writer.sv
// snapshot_writer: captures one windowed frame of packed 12-bit pixels into a frame buffer on request
module snapshot_writer
  import snapshot_writer_pkg::*;
#(
  parameter int WIN_X0 = 0,
  parameter int WIN_Y0 = 0,
  parameter int WIN_W  = 320,
  parameter int WIN_H  = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_req,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [23:0] rgb_in,
  input  logic [2:0]  filter,
  output logic        bram_we,
  output logic [16:0] bram_addr,
  output logic [11:0] bram_din,
  output logic        busy,
  output logic        done,
  output logic [2:0]  snap_filter
);
  logic [1:0]  state, nxt;
  logic        sof, cap, wr, in_win, last;
  logic [16:0] addr;
  assign sof = hcount == 11'd0 && vcount == 10'd0;
  // The frame-start pixel itself belongs to the capture, so writing begins in the ARMED->CAPTURE cycle
  assign cap = state == CAPTURE || (state == ARMED && sof);
  assign wr = cap && in_win;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb
    nxt = state == IDLE ? (capture_req ? ARMED : IDLE) :
          state == DONE ? IDLE :
          (wr && last) ? DONE :
          (state == ARMED && sof) ? CAPTURE : state;
  window_addr_gen #(.WIN_X0(WIN_X0), .WIN_Y0(WIN_Y0), .WIN_W(WIN_W), .WIN_H(WIN_H)) u_gen (
    .clk(clk), .rst(rst), .clr(state == IDLE), .en(cap),
    .hcount(hcount), .vcount(vcount), .in_win(in_win), .addr(addr), .last(last)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state       <= IDLE;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      bram_din    <= '0;
      snap_filter <= '0;
    end else begin
      state   <= nxt;
      bram_we <= wr;
      if (wr) begin
        bram_addr <= addr;
        bram_din  <= pack12(rgb_in);
      end
      if (state == ARMED && sof) snap_filter <= filter;
    end
endmodule
